// File: rtl/main_mem_pkg.sv
// Shared types and default constants for the burst memory block.
package main_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2
  } state_t;

  localparam int DEF_ADDR_W      = 10;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_DEPTH_WORDS = 256;
  localparam int DEF_BURST_LEN   = 4;
  localparam int DEF_LATENCY     = 3;

  // Width of an index over n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/main_mem_burst_if.sv
// Request/beat bus between a burst master and main_mem_burst.
interface main_mem_burst_if
  import main_mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) ();

  localparam int IDX_W = idx_width(BURST_LEN);

  logic                        req_valid;
  logic                        req_ready;
  logic                        req_write;
  logic [ADDR_W-1:0]           req_addr;
  logic [BURST_LEN*DATA_W-1:0] wr_block;
  logic                        beat_valid;
  logic                        beat_last;
  logic [IDX_W-1:0]            beat_idx;
  logic [DATA_W-1:0]           rd_data;

  modport master (
    output req_valid, req_write, req_addr, wr_block,
    input  req_ready, beat_valid, beat_last, beat_idx, rd_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, wr_block,
    output req_ready, beat_valid, beat_last, beat_idx, rd_data
  );

endinterface

// File: rtl/main_mem_array.sv
// Single-port word storage: synchronous write, combinational read.
module main_mem_array #(
  parameter int    DATA_W      = 32,
  parameter int    DEPTH_WORDS = 256,
  parameter int    AW          = $clog2(DEPTH_WORDS),
  parameter string INIT_FILE   = ""
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Write port: storage is never touched by reset.
  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/main_mem_burst.sv
// Burst memory: accepts one block request at a time, waits LATENCY
// cycles, then moves BURST_LEN words with one registered beat per cycle.
// Optional feature macro: MAIN_MEM_CRITICAL_WORD_FIRST_EN (reads start at
// the requested word and wrap within the block).
module main_mem_burst
  import main_mem_pkg::*;
#(
  parameter int    ADDR_W      = DEF_ADDR_W,
  parameter int    DATA_W      = DEF_DATA_W,
  parameter int    DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter int    BURST_LEN   = DEF_BURST_LEN,
  parameter int    LATENCY     = DEF_LATENCY,
  parameter string INIT_FILE   = ""
) (
  input  logic             clock,
  input  logic             reset,
  main_mem_burst_if.slave  bus
);

  localparam int IDX_W = idx_width(BURST_LEN);
  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = idx_width(LATENCY);
  localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_NUM = IDX_W'(BURST_LEN - 1);

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            bcnt_q;
  logic [IDX_W-1:0]            issue_num;
  logic [IDX_W-1:0]            issue_off;
  logic                        issue;
  logic                        accept;

  logic                        wr_q;
  logic [AW-1:0]               base_q;
  logic [BURST_LEN*DATA_W-1:0] block_q;
  logic [ADDR_W-3:0]           req_word;

  logic                        beat_valid_q;
  logic                        beat_last_q;
  logic [IDX_W-1:0]            beat_idx_q;
  logic [DATA_W-1:0]           rd_data_q;

  logic                        mem_we;
  logic [AW-1:0]               mem_addr;
  logic [DATA_W-1:0]           mem_wdata;
  logic [DATA_W-1:0]           mem_rdata;

  assign req_word      = bus.req_addr[ADDR_W-1:2];
  assign bus.req_ready = (state_q == IDLE);
  assign accept        = bus.req_valid && (state_q == IDLE);

  // Next state and beat issue: a beat is launched on the edge that ends
  // the latency wait and on every XFER edge until the last word.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    issue     = 1'b0;
    issue_num = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = XFER;
          issue   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      XFER: begin
        if (bcnt_q == LAST_NUM) begin
          state_d = IDLE;
        end else begin
          issue     = 1'b1;
          issue_num = bcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0] start_q;

  function automatic logic [IDX_W-1:0] wrap_off(input logic [IDX_W-1:0] start,
                                                input logic [IDX_W-1:0] num);
    return (start + num) & IDX_MASK;
  endfunction

  // Requested word offset inside the block, used only to rotate reads.
  always_ff @(posedge clock) begin
    if (accept) start_q <= IDX_W'(req_word) & IDX_MASK;
  end

  assign issue_off = wr_q ? (issue_num & IDX_MASK) : wrap_off(start_q, issue_num);
`else
  assign issue_off = issue_num & IDX_MASK;
`endif

  // Request capture: attributes are frozen at acceptance.
  always_ff @(posedge clock) begin
    if (accept) begin
      wr_q    <= bus.req_write;
      base_q  <= AW'(req_word) & ~AW'(IDX_MASK);
      block_q <= bus.wr_block;
    end
  end

  // A write beat commits its word at the edge that ends the beat, so the
  // single port is addressed by the current beat while writing and by the
  // beat about to be launched while reading.
  assign mem_we    = (state_q == XFER) && wr_q;
  assign mem_addr  = base_q | AW'(mem_we ? beat_idx_q : issue_off);
  assign mem_wdata = block_q[int'(beat_idx_q)*DATA_W +: DATA_W];

  main_mem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW),
    .INIT_FILE   (INIT_FILE)
  ) u_array (
    .clock (clock),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // FSM state, counters and registered beat outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bcnt_q       <= '0;
      beat_valid_q <= 1'b0;
      beat_last_q  <= 1'b0;
      beat_idx_q   <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      beat_valid_q <= issue;
      beat_last_q  <= issue && (issue_num == LAST_NUM);
      if (issue) begin
        bcnt_q     <= issue_num;
        beat_idx_q <= issue_off;
        if (!wr_q) rd_data_q <= mem_rdata;
      end
    end
  end

  assign bus.beat_valid = beat_valid_q;
  assign bus.beat_last  = beat_last_q;
  assign bus.beat_idx   = beat_idx_q;
  assign bus.rd_data    = rd_data_q;

endmodule
